// File: rtl/ext_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : ext_mem_arbiter                                            |
// | Desc    : imem/dmem arbiter onto one external memory bus, timeout.   |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module ext_mem_arbiter #(
  parameter int WORD_SIZE      = 32,
  parameter int MAX_DMEM_BURST = 4,
  parameter int TIMEOUT        = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic [31:0]          imem_addr,
  output logic                 imem_ack,
  output logic [WORD_SIZE-1:0] imem_rdata,
  input  logic                 dmem_req,
  input  logic                 dmem_we,
  input  logic [31:0]          dmem_addr,
  input  logic [WORD_SIZE-1:0] dmem_wdata,
  output logic                 dmem_ack,
  output logic [WORD_SIZE-1:0] dmem_rdata,
  output logic [31:0]          mem_addr,
  output logic [WORD_SIZE-1:0] data_in,
  input  logic [WORD_SIZE-1:0] data_out,
  output logic                 en_ext_mem_re,
  output logic                 en_ext_mem_wr,
  input  logic                 mem_ready,
  output logic                 timeout_err
);

  localparam int c_STREAK_W = $clog2(MAX_DMEM_BURST + 1);
  localparam int c_TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DMEM_BURST);
  localparam logic [c_TMO_W-1:0]    c_TMO_LAST   = c_TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IMEM_OP = 2'd1,
    S_DMEM_OP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [c_STREAK_W-1:0]  r_streak;
  logic [c_TMO_W-1:0]     r_tmo_cnt;
  logic                   r_we;
  logic                   r_imem_ack;
  logic                   r_dmem_ack;
  logic                   r_terr;
  logic                   r_re;
  logic                   r_wr;
  logic [31:0]            r_mem_addr;
  logic [WORD_SIZE-1:0]   r_data_in;
  logic [WORD_SIZE-1:0]   r_imem_rdata;
  logic [WORD_SIZE-1:0]   r_dmem_rdata;

  logic w_streak_full;
  logic w_dmem_wins;
  logic w_grant_d;
  logic w_grant_i;
  logic w_in_op;
  logic w_tmo_hit;
  logic w_done;

  // A still-asserted req from the port acked this cycle is not re-granted,
  // but if it would win arbitration it holds off the other port for a cycle.
  always_comb begin
    w_streak_full = (r_streak == c_STREAK_MAX);
    w_dmem_wins   = dmem_req && !(w_streak_full && imem_req);
    w_grant_d     = (r_state == S_IDLE) && w_dmem_wins && !r_dmem_ack;
    w_grant_i     = (r_state == S_IDLE) && !w_dmem_wins && imem_req && !r_imem_ack;
    w_in_op       = (r_state != S_IDLE);
    w_tmo_hit     = w_in_op && !mem_ready && (r_tmo_cnt == c_TMO_LAST);
    w_done        = w_in_op && (mem_ready || w_tmo_hit);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = S_DMEM_OP;
        end else if (w_grant_i) begin
          w_state_nxt = S_IMEM_OP;
        end
      end
      S_IMEM_OP, S_DMEM_OP: begin
        if (w_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak     <= '0;
      r_tmo_cnt    <= '0;
      r_we         <= 1'b0;
      r_imem_ack   <= 1'b0;
      r_dmem_ack   <= 1'b0;
      r_terr       <= 1'b0;
      r_re         <= 1'b0;
      r_wr         <= 1'b0;
      r_mem_addr   <= '0;
      r_data_in    <= '0;
      r_imem_rdata <= '0;
      r_dmem_rdata <= '0;
    end else begin
      r_imem_ack <= w_done && (r_state == S_IMEM_OP);
      r_dmem_ack <= w_done && (r_state == S_DMEM_OP);
      r_terr     <= w_tmo_hit;

      if (w_grant_d) begin
        r_mem_addr <= dmem_addr;
        r_data_in  <= dmem_wdata;
        r_we       <= dmem_we;
        r_re       <= !dmem_we;
        r_wr       <= dmem_we;
      end else if (w_grant_i) begin
        r_mem_addr <= imem_addr;
        r_we       <= 1'b0;
        r_re       <= 1'b1;
        r_wr       <= 1'b0;
      end else if (w_done) begin
        r_re <= 1'b0;
        r_wr <= 1'b0;
      end

      if (w_grant_d || w_grant_i) begin
        r_tmo_cnt <= '0;
      end else if (w_in_op && !mem_ready && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + c_TMO_W'(1);
      end

      if (r_state == S_IMEM_OP) begin
        if (mem_ready) begin
          r_imem_rdata <= data_out;
        end else if (w_tmo_hit) begin
          r_imem_rdata <= '0;
        end
      end

      // Writes leave dmem_rdata untouched; only an abort clears it.
      if (r_state == S_DMEM_OP) begin
        if (mem_ready) begin
          if (!r_we) begin
            r_dmem_rdata <= data_out;
          end
        end else if (w_tmo_hit) begin
          r_dmem_rdata <= '0;
        end
      end

      if (!imem_req || w_grant_i) begin
        r_streak <= '0;
      end else if (w_grant_d && !w_streak_full) begin
        r_streak <= r_streak + c_STREAK_W'(1);
      end
    end
  end

  assign imem_ack      = r_imem_ack;
  assign dmem_ack      = r_dmem_ack;
  assign imem_rdata    = r_imem_rdata;
  assign dmem_rdata    = r_dmem_rdata;
  assign mem_addr      = r_mem_addr;
  assign data_in       = r_data_in;
  assign en_ext_mem_re = r_re;
  assign en_ext_mem_wr = r_wr;
  assign timeout_err   = r_terr;

endmodule
`default_nettype wire

// File: tb/tb_ext_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_ext_mem_arbiter                                         |
// | Desc    : directed + random bench for ext_mem_arbiter vs ref model.  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_ext_mem_arbiter;

  localparam int WS   = 32;
  localparam int MAXB = 4;
  localparam int TMO  = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [WS-1:0] imem_rdata;
  logic          dmem_req;
  logic          dmem_we;
  logic [31:0]   dmem_addr;
  logic [WS-1:0] dmem_wdata;
  logic          dmem_ack;
  logic [WS-1:0] dmem_rdata;
  logic [31:0]   mem_addr;
  logic [WS-1:0] data_in;
  logic [WS-1:0] data_out;
  logic          en_ext_mem_re;
  logic          en_ext_mem_wr;
  logic          mem_ready;
  logic          timeout_err;

  always #5 clk = ~clk;

  ext_mem_arbiter #(.WORD_SIZE(WS), .MAX_DMEM_BURST(MAXB), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_addr(mem_addr), .data_in(data_in), .data_out(data_out),
    .en_ext_mem_re(en_ext_mem_re), .en_ext_mem_wr(en_ext_mem_wr),
    .mem_ready(mem_ready), .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which port owns the bus (0 none, 1 imem, 2 dmem),
  // how long it has waited, and the last values handed to each side.
  int          m_busy, m_wait, m_streak;
  bit          m_we, m_iack, m_dack, m_terr;
  logic [31:0] m_addr;
  logic [WS-1:0] m_wdata, m_irdata, m_drdata;

  bit rnd, i_keep, d_keep;

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_streak = 0; m_we = 0;
    m_iack = 0; m_dack = 0; m_terr = 0;
    m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
  endtask

  task automatic model_edge();
    bit ia, da, te, fin, imem_first;
    int g;
    ia = 0; da = 0; te = 0; fin = 0; g = 0;
    if (m_busy != 0) begin
      if (mem_ready) fin = 1;
      else if (m_wait + 1 >= TMO) begin fin = 1; te = 1; end
      else m_wait++;
      if (fin) begin
        if (m_busy == 1) begin
          ia = 1;
          m_irdata = te ? '0 : data_out;
        end else begin
          da = 1;
          if (te) m_drdata = '0;
          else if (!m_we) m_drdata = data_out;
        end
        m_busy = 0;
      end
    end else begin
      imem_first = !dmem_req || (m_streak >= MAXB && imem_req);
      if (!imem_first) begin
        if (!m_dack) g = 2;
      end else if (imem_req && !m_iack) g = 1;
    end
    if (!imem_req || g == 1) m_streak = 0;
    else if (g == 2) m_streak = (m_streak + 1 > MAXB) ? MAXB : m_streak + 1;
    if (g == 2) begin
      m_busy = 2; m_wait = 0; m_addr = dmem_addr; m_wdata = dmem_wdata; m_we = dmem_we;
    end else if (g == 1) begin
      m_busy = 1; m_wait = 0; m_addr = imem_addr; m_we = 0;
    end
    m_iack = ia; m_dack = da; m_terr = te;
  endtask

  task automatic compare();
    chk("en_re",   en_ext_mem_re, (m_busy == 1) || (m_busy == 2 && !m_we));
    chk("en_wr",   en_ext_mem_wr, (m_busy == 2) && m_we);
    chk("addr",    mem_addr, m_addr);
    chk("data_in", data_in, m_wdata);
    chk("iack",    imem_ack, m_iack);
    chk("dack",    dmem_ack, m_dack);
    chk("terr",    timeout_err, m_terr);
    chk("irdata",  imem_rdata, m_irdata);
    chk("drdata",  dmem_rdata, m_drdata);
  endtask

  task automatic drive();
    if (rnd) begin
      mem_ready = ($urandom_range(3) != 0);
      data_out  = $urandom;
    end
    if (imem_req && m_iack) begin
      if (rnd) begin i_keep = $urandom_range(1); imem_addr = $urandom; end
      imem_req = i_keep;
    end else if (rnd && imem_req && m_busy == 1 && $urandom_range(15) == 0) begin
      imem_req = 0;
    end else if (rnd && !imem_req && $urandom_range(2) == 0) begin
      imem_req = 1; imem_addr = $urandom;
    end
    if (dmem_req && m_dack) begin
      if (rnd) begin
        d_keep = $urandom_range(1); dmem_addr = $urandom;
        dmem_we = $urandom_range(1); dmem_wdata = $urandom;
      end
      dmem_req = d_keep;
    end else if (rnd && dmem_req && m_busy == 2 && $urandom_range(15) == 0) begin
      dmem_req = 0;
    end else if (rnd && !dmem_req && $urandom_range(2) == 0) begin
      dmem_req = 1; dmem_addr = $urandom; dmem_we = $urandom_range(1); dmem_wdata = $urandom;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_edge();
    #1;
    drive();
    @(negedge clk);
    compare();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int q[$];
    int n;
    bit found;
    rst = 0; rnd = 0; i_keep = 0; d_keep = 0;
    imem_req = 0; imem_addr = '0; dmem_req = 0; dmem_we = 0; dmem_addr = '0;
    dmem_wdata = '0; data_out = '0; mem_ready = 0;
    model_reset();
    repeat (2) @(negedge clk);
    compare();
    rst = 1;
    cycle();

    // Single fetch
    imem_req = 1; imem_addr = 32'h100; data_out = 32'hDEADBEEF; mem_ready = 1;
    cycle();
    chk("t036_re", en_ext_mem_re, 1);
    chk("t036_addr", mem_addr, 32'h100);
    cycle();
    chk("t036_ack", imem_ack, 1);
    chk("t036_rdata", imem_rdata, 32'hDEADBEEF);
    cycle();

    // Simultaneous requests: dmem first, imem in the dmem ack cycle
    imem_req = 1; imem_addr = 32'h300;
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h200; dmem_wdata = 32'h12345678;
    cycle();
    chk("t037_wr", en_ext_mem_wr, 1);
    chk("t037_din", data_in, 32'h12345678);
    chk("t037_addr", mem_addr, 32'h200);
    cycle();
    chk("t037_dack", dmem_ack, 1);
    cycle();
    chk("t037_igrant", en_ext_mem_re, 1);
    chk("t037_iaddr", mem_addr, 32'h300);
    cycle();
    chk("t037_iack", imem_ack, 1);
    cycle();

    // Both held: 4 dmem, 1 imem, repeating
    i_keep = 1; d_keep = 1; data_out = 32'hA5A50000;
    imem_req = 1; dmem_req = 1; dmem_we = 0; dmem_addr = 32'h240;
    for (int c = 0; c < 60; c++) begin
      cycle();
      if (dmem_ack) q.push_back(2);
      if (imem_ack) q.push_back(1);
    end
    chk("t038_count", q.size() >= 15, 1);
    if (q.size() >= 15)
      for (int k = 0; k < 15; k++) chk($sformatf("t038_order%0d", k), q[k], (k % 5 == 4) ? 1 : 2);
    i_keep = 0; d_keep = 0;
    for (int c = 0; c < 20 && (imem_req || dmem_req || m_busy != 0); c++) cycle();
    chk("t038_drained", imem_req || dmem_req, 0);
    cycle();

    // Timeout on a dmem read
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h400; mem_ready = 0;
    n = 0; found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      cycle(); n++;
      if (dmem_ack) found = 1;
    end
    chk("t039_seen", found, 1);
    chk("t039_lat", n, 256);
    chk("t039_terr", timeout_err, 1);
    chk("t039_rdata", dmem_rdata, 0);
    cycle();
    chk("t039_idle", en_ext_mem_re, 0);

    // mem_ready on the exact timeout cycle
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h480; mem_ready = 0;
    for (int c = 0; c < 255; c++) cycle();
    chk("t041_noack", dmem_ack, 0);
    mem_ready = 1; data_out = 32'hCAFEF00D;
    cycle();
    chk("t041_ack", dmem_ack, 1);
    chk("t041_terr", timeout_err, 0);
    chk("t041_rdata", dmem_rdata, 32'hCAFEF00D);
    cycle();

    // Reset in the middle of a dmem write
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h600; dmem_wdata = 32'h55AA55AA; mem_ready = 0;
    cycle();
    chk("t040_wr", en_ext_mem_wr, 1);
    #2;
    imem_req = 1; imem_addr = 32'h500; dmem_req = 0; rst = 0;
    #1;
    chk("t040_wr_drop", en_ext_mem_wr, 0);
    chk("t040_dack", dmem_ack, 0);
    model_reset();
    @(negedge clk);
    compare();
    rst = 1; mem_ready = 1; data_out = 32'h13572468;
    found = 0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle();
      if (imem_ack) found = 1;
    end
    chk("t040_iack", found, 1);
    chk("t040_rdata", imem_rdata, 32'h13572468);
    cycle();

    // Random traffic
    rnd = 1;
    for (int c = 0; c < 4000; c++) cycle();
    rnd = 0; i_keep = 0; d_keep = 0; mem_ready = 1;
    for (int c = 0; c < 40; c++) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
